// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file and a write sideband strobe.
// Auto-incrementing writes and reads behind an 8-bit register pointer.
//
// Ports:
//   aclk, aresetn  system clock, async active-low reset
//   SCL_I, SDA_I   bus levels (oversampled on aclk)
//   SDA_O, SDA_T   open-drain SDA: O is tied 0, T=1 releases the line
//   busy           device address matched, until STOP or next START
//   wr_valid       one-cycle pulse per byte written, with wr_addr/wr_data
module i2c_target_regfile #(
  parameter logic [6:0] P_DEV_ADDR  = 7'h41,
  parameter int         P_MEM_DEPTH = 256,
  parameter int         P_FILTER    = 2
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       SCL_I,
  input  logic       SDA_I,
  output logic       SDA_O,
  output logic       SDA_T,
  output logic       busy,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);

  localparam int AW = (P_MEM_DEPTH > 1) ? $clog2(P_MEM_DEPTH) : 1;
  localparam int CW = $clog2(P_FILTER + 1);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, REG, REG_ACK,
    WR, WR_ACK, RD, RD_ACK, WAIT
  } state_t;

  // index 0 = SCL, index 1 = SDA
  logic [1:0]         s1, s2, filt, prev;
  logic [1:0][CW-1:0] cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1   <= '1;
      s2   <= '1;
      filt <= '1;
      prev <= '1;
      cnt  <= '0;
    end else begin
      s1   <= {SDA_I, SCL_I};
      s2   <= s1;
      prev <= filt;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] != filt[i]) begin
          if (cnt[i] == CW'(P_FILTER - 1)) begin
            filt[i] <= s2[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  logic scl_rise, scl_fall, start_c, stop_c;

  assign scl_rise = filt[0] & ~prev[0];
  assign scl_fall = ~filt[0] & prev[0];
  assign start_c  = filt[0] & prev[0] & prev[1] & ~filt[1];
  assign stop_c   = filt[0] & prev[0] & ~prev[1] & filt[1];

  state_t        state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          rw;
  logic [AW-1:0] ptr;
  logic [7:0]    mem [P_MEM_DEPTH];
  logic [7:0]    rx_byte;
  logic [7:0]    rd_byte;

  assign rx_byte = {shreg[6:0], filt[1]};
  assign rd_byte = mem[ptr];
  assign SDA_O   = 1'b0;

  // Array write trails the strobe by one cycle; nothing reads
  // that location within the following SCL period.
  always_ff @(posedge aclk) begin
    if (wr_valid) mem[wr_addr[AW-1:0]] <= wr_data;
  end

  // bit_cnt: 0..8 data bits, 8/9 bracket the ACK clock in *_ACK.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      rw       <= 1'b0;
      ptr      <= '0;
      SDA_T    <= 1'b1;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (start_c) begin
        state   <= DEV;
        bit_cnt <= '0;
        SDA_T   <= 1'b1;
        busy    <= 1'b0;
      end else if (stop_c) begin
        state   <= IDLE;
        bit_cnt <= '0;
        SDA_T   <= 1'b1;
        busy    <= 1'b0;
      end else if (scl_rise) begin
        unique case (state)
          DEV: begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (rx_byte[7:1] == P_DEV_ADDR) begin
                state <= DEV_ACK;
                busy  <= 1'b1;
                rw    <= rx_byte[0];
              end else begin
                state <= WAIT;
              end
            end
          end
          REG: begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              ptr   <= rx_byte[AW-1:0];
              state <= REG_ACK;
            end
          end
          WR: begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              wr_valid <= 1'b1;
              wr_addr  <= 8'(ptr);
              wr_data  <= rx_byte;
              ptr      <= ptr + 1'b1;
              state    <= WR_ACK;
            end
          end
          DEV_ACK, REG_ACK, WR_ACK: bit_cnt <= 4'd9;
          RD: bit_cnt <= bit_cnt + 4'd1;
          RD_ACK: begin
            if (filt[1]) begin
              state <= WAIT;
            end else begin
              ptr     <= ptr + 1'b1;
              bit_cnt <= 4'd9;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        unique case (state)
          DEV_ACK, REG_ACK, WR_ACK: begin
            if (bit_cnt == 4'd8) begin
              SDA_T <= 1'b0;
            end else if (bit_cnt == 4'd9) begin
              SDA_T   <= 1'b1;
              bit_cnt <= '0;
              state   <= WR;
              if (state == DEV_ACK) begin
                if (rw) begin
                  state <= RD;
                  shreg <= rd_byte;
                  SDA_T <= rd_byte[7];
                end else begin
                  state <= REG;
                end
              end
            end
          end
          RD: begin
            if (bit_cnt == 4'd8) begin
              SDA_T <= 1'b1;
              state <= RD_ACK;
            end else if (bit_cnt != 4'd0) begin
              SDA_T <= shreg[6];
              shreg <= {shreg[6:0], 1'b0};
            end
          end
          RD_ACK: begin
            if (bit_cnt == 4'd9) begin
              state   <= RD;
              bit_cnt <= '0;
              shreg   <= rd_byte;
              SDA_T   <= rd_byte[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master plus
// a write-strobe scoreboard.
module tb_i2c_target_regfile;

  localparam int Q = 10;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       SDA_O, SDA_T, busy, wr_valid;
  logic [7:0] wr_addr, wr_data;

  assign sda_bus = sda_m & (SDA_T | SDA_O);

  always #5 aclk = ~aclk;

  i2c_target_regfile #(
    .P_DEV_ADDR (7'h41),
    .P_MEM_DEPTH(256),
    .P_FILTER   (3)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .SCL_I   (scl),
    .SDA_I   (sda_bus),
    .SDA_O   (SDA_O),
    .SDA_T   (SDA_T),
    .busy    (busy),
    .wr_valid(wr_valid),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  int          checks = 0;
  int          errors = 0;
  int          t_low_cnt = 0;
  logic [15:0] sb[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (!SDA_T) t_low_cnt++;
    if (aresetn && wr_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h expected none",
                 wr_addr, wr_data);
      end else begin
        chk("wr_strobe", {16'h0, wr_addr, wr_data}, {16'h0, sb.pop_front()});
      end
    end
  end

  task automatic wq();
    repeat (Q) @(negedge aclk);
  endtask

  task automatic m_start();
    sda_m = 1'b1; wq();
    scl = 1'b1;   wq();
    sda_m = 1'b0; wq();
    scl = 1'b0;   wq();
  endtask

  task automatic m_stop();
    sda_m = 1'b0; wq();
    scl = 1'b1;   wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic bit_io(input logic b, output logic r);
    sda_m = b; wq();
    scl = 1'b1; wq();
    r = sda_bus; wq();
    scl = 1'b0; wq();
  endtask

  // SCL-high window carries a 2-cycle inverted SDA pulse
  task automatic bit_glitch(input logic b);
    sda_m = b; wq();
    scl = 1'b1;
    repeat (4) @(negedge aclk);
    sda_m = ~b;
    repeat (2) @(negedge aclk);
    sda_m = b;
    repeat (4) @(negedge aclk);
    scl = 1'b0; wq();
  endtask

  task automatic wr_byte(input logic [7:0] v, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(v[i], r);
    bit_io(1'b1, ack);
  endtask

  task automatic rd_byte(input logic ack, output logic [7:0] v);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r);
      v[i] = r;
    end
    bit_io(ack, r);
  endtask

  typedef struct packed {
    logic [7:0]      dev;
    logic [7:0]      rg;
    logic [1:0]      n;
    logic [1:0][7:0] d;
    logic            hit;
  } vec_t;

  vec_t tv [3];

  initial begin
    logic       a, r;
    logic [7:0] v, wa;
    int         t0;

    tv[0] = '{dev: 8'h82, rg: 8'h10, n: 2'd2,
              d: {8'h5A, 8'hA5}, hit: 1'b1};
    tv[1] = '{dev: 8'h84, rg: 8'h10, n: 2'd1,
              d: {8'h00, 8'h33}, hit: 1'b0};
    tv[2] = '{dev: 8'h82, rg: 8'hFF, n: 2'd2,
              d: {8'h22, 8'h11}, hit: 1'b1};

    repeat (5) @(negedge aclk);
    chk("rst_sda_t", {31'h0, SDA_T}, 32'h1);
    chk("rst_sda_o", {31'h0, SDA_O}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_wr_valid", {31'h0, wr_valid}, 32'h0);
    chk("rst_wr_addr", {24'h0, wr_addr}, 32'h0);
    chk("rst_wr_data", {24'h0, wr_data}, 32'h0);
    aresetn = 1'b1;
    wq();

    for (int k = 0; k < 3; k++) begin
      t0 = t_low_cnt;
      m_start();
      wr_byte(tv[k].dev, a);
      chk("dev_ack", {31'h0, a}, {31'h0, !tv[k].hit});
      wr_byte(tv[k].rg, a);
      chk("reg_ack", {31'h0, a}, {31'h0, !tv[k].hit});
      chk("busy_mid", {31'h0, busy}, {31'h0, tv[k].hit});
      for (int i = 0; i < int'(tv[k].n); i++) begin
        wa = tv[k].rg + 8'(i);
        if (tv[k].hit) sb.push_back({wa, tv[k].d[i]});
        wr_byte(tv[k].d[i], a);
        chk("data_ack", {31'h0, a}, {31'h0, !tv[k].hit});
      end
      if (!tv[k].hit) chk("nomatch_sda_t_low", t_low_cnt - t0, 32'h0);
      m_stop();
      wq();
      chk("busy_after_stop", {31'h0, busy}, 32'h0);
      chk("wr_count", sb.size(), 32'h0);
    end

    m_start();
    wr_byte(8'h82, a); chk("rr_dev_ack", {31'h0, a}, 32'h0);
    wr_byte(8'h10, a); chk("rr_reg_ack", {31'h0, a}, 32'h0);
    m_start();
    wr_byte(8'h83, a); chk("rr_rdev_ack", {31'h0, a}, 32'h0);
    rd_byte(1'b0, v);  chk("rr_byte0", {24'h0, v}, 32'hA5);
    rd_byte(1'b1, v);  chk("rr_byte1", {24'h0, v}, 32'h5A);
    chk("rr_sda_released", {31'h0, SDA_T}, 32'h1);
    m_stop();

    m_start();
    wr_byte(8'h82, a); chk("wrap_dev_ack", {31'h0, a}, 32'h0);
    wr_byte(8'hFF, a); chk("wrap_reg_ack", {31'h0, a}, 32'h0);
    m_start();
    wr_byte(8'h83, a); chk("wrap_rdev_ack", {31'h0, a}, 32'h0);
    rd_byte(1'b0, v);  chk("wrap_byte0", {24'h0, v}, 32'h11);
    rd_byte(1'b1, v);  chk("wrap_byte1", {24'h0, v}, 32'h22);
    m_stop();

    m_start();
    wr_byte(8'h82, a);
    wr_byte(8'h21, a);
    sb.push_back(16'h2199);
    wr_byte(8'h99, a); chk("ab_pre_ack", {31'h0, a}, 32'h0);
    m_stop();
    m_start();
    wr_byte(8'h82, a);
    wr_byte(8'h20, a);
    sb.push_back(16'h2077);
    wr_byte(8'h77, a);
    v = 8'hC3;
    for (int i = 7; i >= 4; i--) bit_io(v[i], r);
    m_stop();
    m_start();
    wr_byte(8'h83, a); chk("ab_rdev_ack", {31'h0, a}, 32'h0);
    rd_byte(1'b1, v);  chk("ab_ptr_kept", {24'h0, v}, 32'h99);
    m_stop();
    chk("ab_wr_count", sb.size(), 32'h0);

    m_start();
    v = 8'h83;
    for (int i = 7; i >= 0; i--) bit_io(v[i], r);
    chk("rs_ack_driven", {31'h0, SDA_T}, 32'h0);
    aresetn = 1'b0;
    #1;
    chk("rs_async_release", {31'h0, SDA_T}, 32'h1);
    wq();
    aresetn = 1'b1;
    wq();
    t0 = t_low_cnt;
    wr_byte(8'h82, a); chk("rs_nostart_dev", {31'h0, a}, 32'h1);
    wr_byte(8'h10, a); chk("rs_nostart_reg", {31'h0, a}, 32'h1);
    wr_byte(8'h55, a); chk("rs_nostart_dat", {31'h0, a}, 32'h1);
    chk("rs_busy", {31'h0, busy}, 32'h0);
    chk("rs_sda_t_low", t_low_cnt - t0, 32'h0);
    m_stop();

    m_start();
    wr_byte(8'h82, a); chk("gl_dev_ack", {31'h0, a}, 32'h0);
    wr_byte(8'h30, a); chk("gl_reg_ack", {31'h0, a}, 32'h0);
    sb.push_back(16'h303C);
    v = 8'h3C;
    for (int i = 7; i >= 0; i--) begin
      if (i == 5 || i == 1) bit_glitch(v[i]);
      else bit_io(v[i], r);
    end
    bit_io(1'b1, a);
    chk("gl_data_ack", {31'h0, a}, 32'h0);
    chk("gl_busy", {31'h0, busy}, 32'h1);
    m_stop();
    wq();
    chk("gl_wr_count", sb.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
